multi_debouncer: RTL

Parametrised, multi-channel push-button conditioner for the vending-machine front panel. It replaces per-button debouncing on a divided clock with a single-clock design driven by a sample-enable `tick`. Each channel has a synchroniser, a consecutive-sample stability counter, one-cycle press/release pulses and a long-hold flag. It sits between the raw board buttons and the vending FSM.

---
 rtl/debounce_pkg.sv | 16 +
 rtl/debounce_channel.sv | 106 ++++++++++
 rtl/multi_debouncer.sv | 47 ++++
 3 files changed

// File: rtl/debounce_pkg.sv
// Shared types for the front-panel button conditioner: per-channel debounce
// state encoding and an elaboration-time parameter sanity check.
package debounce_pkg;

  typedef enum logic [1:0] {
    LOW    = 2'b00,
    CHK_HI = 2'b01,
    HIGH   = 2'b10,
    CHK_LO = 2'b11
  } db_state_e;

  function automatic bit params_ok(input int stable_ticks, input int sync_stages);
    return (stable_ticks >= 1) && (sync_stages >= 2);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: synchroniser, consecutive-sample debounce FSM,
// registered rise/fall pulses and a saturating long-hold counter.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int STABLE_TICKS = 4,
  parameter int HOLD_TICKS   = 200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic in,
  output logic out,
  output logic rise,
  output logic fall,
  output logic held
);

  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  if (!params_ok(STABLE_TICKS, SYNC_STAGES)) begin : g_bad_params
    $error("debounce_channel: STABLE_TICKS must be >= 1 and SYNC_STAGES >= 2");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  db_state_e              state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   out_next;

  assign s = sync_q[SYNC_STAGES-1];

  // NOTE: every clocked process uses non-blocking assignments so all flops
  // sample pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOW;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: defaults first so every path assigns state_d/cnt_d and no latch
  // is inferred when tick is low.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (tick) begin
      if (s == out) begin
        // Any agreeing sample abandons a pending change.
        cnt_d   = '0;
        state_d = out ? HIGH : LOW;
      end else if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        state_d = out ? LOW : HIGH;
      end else begin
        cnt_d   = cnt_q + CW'(1);
        state_d = out ? CHK_LO : CHK_HI;
      end
    end
  end

  always_comb begin
    out = (state_q == HIGH) || (state_q == CHK_LO);
  end

  assign out_next = (state_d == HIGH) || (state_d == CHK_LO);

  // Pulses land in the same cycle as the new out level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= out_next & ~out;
      fall <= ~out_next & out;
    end
  end

  if (HOLD_TICKS > 0) begin : g_hold
    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TICKS);
    logic [HW-1:0] hcnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                           hcnt_q <= '0;
      else if (!out)                        hcnt_q <= '0;
      else if (tick && hcnt_q != HOLD_MAX)  hcnt_q <= hcnt_q + HW'(1);
    end

    // Gating with out drops held in the same cycle out falls.
    assign held = out && (hcnt_q == HOLD_MAX);
  end else begin : g_no_hold
    assign held = 1'b0;
  end

endmodule

// File: rtl/multi_debouncer.sv
// Multi-channel push-button conditioner: reset-release synchroniser plus
// N_CH independent debounce channels sharing one sample-enable tick.
module multi_debouncer #(
  parameter int N_CH         = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int STABLE_TICKS = 4,
  parameter int HOLD_TICKS   = 200
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tick,
  input  logic [N_CH-1:0] in,
  output logic [N_CH-1:0] out,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] held
);

  // Assertion is asynchronous; release reaches the channels two edges later.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync_q <= '0;
    else      rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .STABLE_TICKS(STABLE_TICKS),
      .HOLD_TICKS  (HOLD_TICKS)
    ) u_channel (
      .clk  (clk),
      .rst_n(rst_n),
      .tick (tick),
      .in   (in[i]),
      .out  (out[i]),
      .rise (rise[i]),
      .fall (fall[i]),
      .held (held[i])
    );
  end

endmodule
